// File: rtl/lfsr_noise_pkg.sv
// Shared types and constants for the LFSR noise voice.
// Envelope state encoding and noise datapath geometry.
package lfsr_noise_pkg;

  localparam int LFSR_W = 31;
  localparam int TAP_A  = 30;
  localparam int TAP_B  = 27;
  localparam int LP_W   = 18;

  localparam logic [LFSR_W-1:0] DEF_SEED = 31'h5555_5555;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_st_e;

endpackage

// File: rtl/lfsr_lowpass_noise.sv
// 31-bit LFSR noise source, one-pole shift lowpass and gain shift.
// Produces the 16-bit signed scaled noise sample every clock.
module lfsr_lowpass_noise
  import lfsr_noise_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEF_SEED
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [2:0]         i_cutoff,
  input  logic [2:0]         i_gain,
  output logic signed [15:0] o_scaled
);

  logic [LFSR_W-1:0]      r_lfsr;
  logic signed [LP_W-1:0] r_lp;
  logic signed [LP_W-1:0] w_diff;
  logic signed [LP_W-1:0] w_step;
  logic                   w_fb;

  assign w_fb   = r_lfsr[TAP_A] ^ r_lfsr[TAP_B];
  assign w_diff = $signed(r_lfsr[LP_W-1:0]) - r_lp;
  assign w_step = w_diff >>> i_cutoff;

  // Drop the two LSBs of the filter state, then gain-shift with wrap.
  assign o_scaled = r_lp[LP_W-1:2] << i_gain;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_lfsr <= SEED;
      r_lp   <= '0;
    end else begin
      r_lfsr <= {r_lfsr[LFSR_W-2:0], w_fb};
      r_lp   <= r_lp + w_step;
    end
  end

endmodule

// File: rtl/lfsr_noise_adsr.sv
// Band-limited noise voice with gated ADSR envelope.
// Tick divider, gate edge detect, envelope FSM and output multiply.
module lfsr_noise_adsr
  import lfsr_noise_pkg::*;
#(
  parameter int                ENV_W         = 16,
  parameter int                TICK_DIV_BITS = 8,
  parameter logic [LFSR_W-1:0] SEED          = DEF_SEED
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               gate,
  input  logic [2:0]         cutoff,
  input  logic [2:0]         gain,
  input  logic [3:0]         attack,
  input  logic [3:0]         decay,
  input  logic [3:0]         release_rate,
  input  logic [ENV_W-1:0]   amp,
  input  logic [ENV_W-1:0]   sustain,
  output logic signed [15:0] noise_out,
  output logic [ENV_W-1:0]   env_out,
  output logic [2:0]         state_out,
  output logic               active
);

  logic signed [15:0]      w_scaled;
  logic [TICK_DIV_BITS-1:0] r_div;
  logic                    w_tick;
  logic                    r_gate_d;
  logic                    w_rise;
  logic                    w_fall;
  env_st_e                 r_state;
  env_st_e                 w_state_nx;
  logic [ENV_W-1:0]        r_env;
  logic [ENV_W-1:0]        w_env_nx;
  logic [ENV_W-1:0]        w_sus;
  logic [ENV_W-1:0]        w_att_step;
  logic [ENV_W-1:0]        w_dec_step;
  logic [ENV_W-1:0]        w_rel_step;
  logic signed [16+ENV_W:0] w_prod;
  logic                    w_unused;

  lfsr_lowpass_noise #(
    .SEED (SEED)
  ) u_noise (
    .clock    (clock),
    .reset    (reset),
    .i_cutoff (cutoff),
    .i_gain   (gain),
    .o_scaled (w_scaled)
  );

  assign w_tick = &r_div;
  assign w_rise = gate & ~r_gate_d;
  assign w_fall = ~gate & r_gate_d;

  assign w_sus      = (sustain < amp) ? sustain : amp;
  assign w_att_step = (amp - r_env) >> attack;
  assign w_dec_step = (r_env - w_sus) >> decay;
  assign w_rel_step = r_env >> release_rate;

  assign w_prod   = w_scaled * $signed({1'b0, r_env});
  assign w_unused = ^{w_prod[16+ENV_W], w_prod[ENV_W-1:0]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_div     <= '0;
      r_gate_d  <= 1'b0;
      noise_out <= '0;
    end else begin
      r_div     <= r_div + TICK_DIV_BITS'(1);
      r_gate_d  <= gate;
      noise_out <= w_prod[ENV_W+15:ENV_W];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_env   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_env   <= w_env_nx;
    end
  end

  // Gate edges win over the tick; env is left untouched on an edge.
  always_comb begin
    w_state_nx = r_state;
    w_env_nx   = r_env;
    if (w_rise) begin
      w_state_nx = ST_ATTACK;
    end else if (w_fall) begin
      if (r_state inside {ST_ATTACK, ST_DECAY, ST_SUSTAIN})
        w_state_nx = ST_RELEASE;
    end else if (w_tick) begin
      unique case (r_state)
        ST_IDLE: begin
          w_env_nx = '0;
        end
        ST_ATTACK: begin
          if (r_env > amp || w_att_step == '0) begin
            w_env_nx   = amp;
            w_state_nx = ST_DECAY;
          end else begin
            w_env_nx = r_env + w_att_step;
          end
        end
        ST_DECAY: begin
          if (r_env <= w_sus || w_dec_step == '0) begin
            w_env_nx   = w_sus;
            w_state_nx = ST_SUSTAIN;
          end else begin
            w_env_nx = r_env - w_dec_step;
          end
        end
        ST_SUSTAIN: begin
          w_env_nx = w_sus;
        end
        ST_RELEASE: begin
          if (w_rel_step == '0) begin
            w_env_nx   = '0;
            w_state_nx = ST_IDLE;
          end else begin
            w_env_nx = r_env - w_rel_step;
          end
        end
        default: begin
          w_env_nx   = '0;
          w_state_nx = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    state_out = r_state;
    env_out   = r_env;
    active    = (r_state != ST_IDLE);
  end

endmodule

// File: tb/tb_lfsr_noise_adsr.sv
// Directed bench for lfsr_noise_adsr with a 4-clock tick.
// Vector table for the envelope plus hand sequences for corners.
module tb_lfsr_noise_adsr;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ATT  = 3'd1;
  localparam logic [2:0] S_DEC  = 3'd2;
  localparam logic [2:0] S_SUS  = 3'd3;
  localparam logic [2:0] S_REL  = 3'd4;
  localparam logic [30:0] SEED  = 31'h5555_5555;

  logic               clock = 1'b0;
  logic               reset;
  logic               gate;
  logic [2:0]         cutoff;
  logic [2:0]         gain;
  logic [3:0]         attack;
  logic [3:0]         decay;
  logic [3:0]         release_rate;
  logic [15:0]        amp;
  logic [15:0]        sustain;
  logic signed [15:0] noise_out;
  logic [15:0]        env_out;
  logic [2:0]         state_out;
  logic               active;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [30:0]        m_lfsr;
  logic signed [17:0] m_lp;
  logic signed [17:0] m_diff;
  logic signed [15:0] m_scaled;
  logic [15:0]        m_top;

  typedef struct {
    string       name;
    logic        g;
    logic [15:0] a;
    logic [15:0] s;
    logic [3:0]  at;
    logic [3:0]  dc;
    logic [3:0]  rl;
    int          clks;
    int          ticks;
    logic [2:0]  st;
    logic [15:0] env;
  } vec_t;

  vec_t vt[$];

  lfsr_noise_adsr #(
    .ENV_W         (16),
    .TICK_DIV_BITS (2),
    .SEED          (SEED)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .gate         (gate),
    .cutoff       (cutoff),
    .gain         (gain),
    .attack       (attack),
    .decay        (decay),
    .release_rate (release_rate),
    .amp          (amp),
    .sustain      (sustain),
    .noise_out    (noise_out),
    .env_out      (env_out),
    .state_out    (state_out),
    .active       (active)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    cyc    = 0;
    m_lfsr = SEED;
    m_lp   = '0;
  endtask

  task automatic clk1();
    @(posedge clock);
    cyc++;
    m_top    = m_lp[17:2];
    m_scaled = m_top << gain;
    m_diff   = $signed(m_lfsr[17:0]) - m_lp;
    m_diff   = m_diff >>> cutoff;
    m_lp     = m_lp + m_diff;
    m_lfsr   = {m_lfsr[29:0], m_lfsr[30] ^ m_lfsr[27]};
    @(negedge clock);
  endtask

  task automatic to_tick();
    do clk1(); while (cyc % 4 != 0);
  endtask

  task automatic chk_noise(string nm);
    int d;
    d = int'(noise_out) - int'(m_scaled);
    n_tests++;
    if (d > 1 || d < -1) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d+-1",
               nm, noise_out, m_scaled);
    end
  endtask

  function automatic void add(
    string nm, logic g, logic [15:0] a, logic [15:0] s,
    logic [3:0] at, logic [3:0] dc, logic [3:0] rl,
    int c, int t, logic [2:0] st, logic [15:0] e);
    vec_t v;
    v.name = nm; v.g = g; v.a = a; v.s = s;
    v.at = at; v.dc = dc; v.rl = rl;
    v.clks = c; v.ticks = t; v.st = st; v.env = e;
    vt.push_back(v);
  endfunction

  initial begin
    logic [15:0] prev;
    logic [15:0] e_env;
    logic [2:0]  e_st;
    bit          done;

    add("att_rise",  1, 16'hFFFF, 16'hFFFF, 0, 0, 2, 1, 0, S_ATT, 16'h0000);
    add("att_tick1", 1, 16'hFFFF, 16'hFFFF, 0, 0, 2, 0, 1, S_ATT, 16'hFFFF);
    add("att_tick2", 1, 16'hFFFF, 16'hFFFF, 0, 0, 2, 0, 1, S_DEC, 16'hFFFF);
    add("att_sus",   1, 16'hFFFF, 16'hFFFF, 0, 0, 2, 0, 1, S_SUS, 16'hFFFF);
    add("fall_sus",  0, 16'hFFFF, 16'hFFFF, 0, 0, 2, 1, 0, S_REL, 16'hFFFF);
    add("rise_rel",  1, 16'h8000, 16'h4000, 0, 1, 2, 1, 0, S_ATT, 16'hFFFF);
    add("amp_low",   1, 16'h8000, 16'h4000, 0, 1, 2, 0, 1, S_DEC, 16'h8000);
    add("dec1",      1, 16'h8000, 16'h4000, 0, 1, 2, 0, 1, S_DEC, 16'h6000);
    add("dec2",      1, 16'h8000, 16'h4000, 0, 1, 2, 0, 1, S_DEC, 16'h5000);
    add("dec3",      1, 16'h8000, 16'h4000, 0, 1, 2, 0, 1, S_DEC, 16'h4800);
    add("dec14",     1, 16'h8000, 16'h4000, 0, 1, 2, 0, 11, S_DEC, 16'h4001);
    add("dec_clamp", 1, 16'h8000, 16'h4000, 0, 1, 2, 0, 1, S_SUS, 16'h4000);
    add("sus_track", 1, 16'h8000, 16'hFFFF, 0, 1, 2, 0, 1, S_SUS, 16'h8000);
    add("sus_back",  1, 16'h8000, 16'h4000, 0, 1, 2, 0, 1, S_SUS, 16'h4000);
    add("rel_fall",  0, 16'h8000, 16'h4000, 0, 1, 2, 1, 0, S_REL, 16'h4000);
    add("rel1",      0, 16'h8000, 16'h4000, 0, 1, 2, 0, 1, S_REL, 16'h3000);
    add("rel2",      0, 16'h8000, 16'h4000, 0, 1, 2, 0, 1, S_REL, 16'h2400);
    add("rel3",      0, 16'h8000, 16'h4000, 0, 1, 2, 0, 1, S_REL, 16'h1B00);
    add("rel4",      0, 16'h8000, 16'h4000, 0, 1, 2, 0, 1, S_REL, 16'h1440);
    add("rel_hold",  0, 16'h8000, 16'h4000, 0, 1, 2, 3, 0, S_REL, 16'h1440);
    add("retrig",    1, 16'h8000, 16'h4000, 1, 1, 2, 1, 0, S_ATT, 16'h1440);
    add("retrig_up1",1, 16'h8000, 16'h4000, 1, 1, 2, 0, 1, S_ATT, 16'h4A20);
    add("retrig_up2",1, 16'h8000, 16'h4000, 1, 1, 2, 0, 1, S_ATT, 16'h6510);
    add("rel2_fall", 0, 16'h8000, 16'h4000, 1, 1, 2, 1, 0, S_REL, 16'h6510);

    reset = 1'b0; gate = 1'b0; cutoff = '0; gain = '0;
    attack = '0; decay = '0; release_rate = 4'd2;
    amp = '0; sustain = '0;

    repeat (2) @(negedge clock);
    chk("rst_noise", noise_out, 0);
    chk("rst_env", env_out, 0);
    chk("rst_state", state_out, S_IDLE);
    chk("rst_active", active, 0);

    reset = 1'b1;
    model_reset();
    chk("lfsr_seed", dut.u_noise.r_lfsr, SEED);
    clk1();
    chk("lfsr_step1", dut.u_noise.r_lfsr, 31'h2AAA_AAAB);
    repeat (3) begin
      clk1();
      chk("idle_noise", noise_out, 0);
      chk("idle_state", state_out, S_IDLE);
    end

    foreach (vt[i]) begin
      gate = vt[i].g; amp = vt[i].a; sustain = vt[i].s;
      attack = vt[i].at; decay = vt[i].dc;
      release_rate = vt[i].rl;
      repeat (vt[i].clks) clk1();
      repeat (vt[i].ticks) to_tick();
      chk({vt[i].name, "_st"}, state_out, vt[i].st);
      chk({vt[i].name, "_env"}, env_out, vt[i].env);
      chk({vt[i].name, "_act"}, active, vt[i].st != S_IDLE);
    end

    prev = 16'h6510;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      to_tick();
      if ((prev >> 2) == 0) begin
        e_env = 16'h0; e_st = S_IDLE; done = 1;
      end else begin
        e_env = prev - (prev >> 2); e_st = S_REL;
      end
      chk("rel_env", env_out, e_env);
      chk("rel_st", state_out, e_st);
      prev = e_env;
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL rel_timeout: got no idle want idle");
    end
    chk("rel_idle_act", active, 0);

    gate = 1'b1; amp = 16'hFFFF; sustain = 16'hFFFF;
    attack = 4'd1; decay = 4'd0;
    clk1();
    chk("ar_rise", state_out, S_ATT);
    to_tick();
    chk("ar_env", env_out, 16'h7FFF);
    #2 reset = 1'b0;
    #1;
    chk("ar_env0", env_out, 0);
    chk("ar_st0", state_out, S_IDLE);
    chk("ar_noise0", noise_out, 0);
    chk("ar_act0", active, 0);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    attack = 4'd0;
    clk1();
    chk("post_rise", state_out, S_ATT);
    chk("post_env", env_out, 0);
    to_tick();
    chk("post_peak", env_out, 16'hFFFF);
    repeat (20) begin
      clk1();
      chk_noise("noise_c0g0");
    end
    chk("post_sus", state_out, S_SUS);
    cutoff = 3'd2; gain = 3'd1;
    repeat (20) begin
      clk1();
      chk_noise("noise_c2g1");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
